memory_cycle: RTL
=================

MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, data-memory byte-address width.
REQ-002 SHALL have ports:
  - clk  in  1  single clock; all state updates on rising edge.
  - rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have EX/MEM-side inputs:
  - RegWriteM  in  1  register-file write enable.
  - MemWriteM  in  1  store.
  - ResultSrcM  in  2  result select; 1 = load.
  - funct3M  in  3  access size/sign.
  - RdM  in  5  destination register.
  - ALUResultM  in  32  effective address / ALU result.
  - WriteDataM  in  32  store data.
  - PCPlus4M  in  32  return address.
REQ-004 SHALL have data-memory ports:
  - dmem_req  out  1  access request.
  - dmem_we  out  1  write strobe.
  - dmem_addr  out  ADDR_W  word-aligned address.
  - dmem_be  out  4  byte enables.
  - dmem_wdata  out  32  lane-aligned store data.
  - dmem_rdata  in  32  read word.
  - dmem_ready  in  1  access complete this cycle.
REQ-005 SHALL have MEM/WB outputs (registered):
  - RegWriteW  out  1  write enable.
  - ResultSrcW  out  2  result select.
  - RdW  out  5  destination register.
  - ALUResultW  out  32  ALU result.
  - ReadDataW  out  32  extended load data.
  - PCPlus4W  out  32  return address.
REQ-006 SHALL have status outputs:
  - StallM  out  1  freeze IF..EX/MEM; combinational.
  - MisalignM  out  1  one-cycle misalignment pulse, registered.

Function
REQ-007 An instruction SHALL be a memory op when MemWriteM=1 or ResultSrcM=1; all other instructions SHALL pass to MEM/WB registers in one cycle, never stalling.
REQ-008 FSM SHALL have states IDLE and WAIT.
REQ-009 In IDLE, an aligned memory op SHALL assert dmem_req; if dmem_ready=1 the same cycle it SHALL complete (latency 1), else the FSM SHALL go to WAIT.
REQ-010 In WAIT, dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata SHALL remain asserted and stable until dmem_ready=1; on ready the FSM SHALL return to IDLE.
REQ-011 StallM SHALL equal (memory op pending) AND NOT dmem_ready.
REQ-012 While StallM=1, MEM/WB SHALL load a bubble: RegWriteW=0, ResultSrcW=0, RdW=0.
REQ-013 dmem_addr SHALL be {ALUResultM[ADDR_W-1:2],2'b00}; dmem_we=MemWriteM.
REQ-014 Stores SHALL map as follows, off = ALUResultM[1:0]:
  - SB (000): be=4'b0001<<off; wdata = byte replicated x4.
  - SH (001): be=0011 (off=0) or 1100 (off=2); wdata = halfword replicated x2.
  - SW (010): be=1111.
REQ-015 Loads SHALL select the lane by offset:
  - LB (000) / LH (001) sign-extend.
  - LBU (100) / LHU (101) zero-extend.
  - LW (010) passes the word.
  - dmem_be SHALL show the accessed lanes.
REQ-016 Misaligned accesses (LH/LHU/SH with off[0]=1; LW/SW with off!=0) and reserved funct3 SHALL issue no dmem_req, SHALL not stall, SHALL write RegWriteW=0, and SHALL pulse MisalignM for one cycle.
REQ-017 ReadDataW SHALL be 0 for non-load instructions.
REQ-018 Back-to-back memory ops SHALL each take at least one cycle; the next op SHALL be sampled in the cycle after completion.

Reset
REQ-019 On rst=1 at a clock edge, all MEM/WB outputs SHALL clear to 0, MisalignM SHALL clear to 0, and the FSM SHALL go to IDLE.
REQ-020 A reset in WAIT SHALL abandon the access: dmem_req SHALL be 0 from the next cycle, with no retry and no write-back.

Structure
REQ-021 Shared package rv32i_pkg SHALL hold:
  - funct3 load/store encodings.
  - ResultSrc encodings (ALU=0, MEM=1, PC4=2).
  - FSM state type.
REQ-022 Lane steering and extension SHALL live in one combinational sub-module, load_store_align; FSM and pipeline registers SHALL remain in memory_cycle.

Verification
REQ-023 Case: LW at 0x100, dmem_rdata=0xDEADBEEF, ready same cycle -> StallM never 1; next cycle ReadDataW=0xDEADBEEF, ResultSrcW=1, RegWriteW=1.
REQ-024 Case: LB at 0x103, rdata=0x80112233 -> ReadDataW=0xFFFFFF80; same access as LBU -> 0x00000080.
REQ-025 Case: SH at 0x202, WriteDataM=0x0000ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x200, dmem_we=1.
REQ-026 Case: LW with dmem_ready held low 3 cycles -> StallM=1 for 3 cycles, signals stable, bubbles written; data registered on the 4th cycle.
REQ-027 Case: LW at 0x102 -> no dmem_req, MisalignM=1 for one cycle, RegWriteW=0.
REQ-028 Case: rst asserted in WAIT -> next cycle all outputs 0, dmem_req=0; a following aligned LW completes normally.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings for the memory stage: load/store funct3 codes,
// result-select values and the data-memory handshake state.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } resultSrc_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } memState_e;

  // Byte lanes touched by an access of the given size starting at byte offset off.
  function automatic logic [3:0] laneMask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/memory_cycle_if.sv
// Data-memory request/response bus; master is the memory stage, slave the memory.
interface memory_cycle_if #(
  parameter int ADDR_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/load_store_align.sv
// Combinational lane steering: legality check, byte enables, store replication
// and load lane extraction with sign/zero extension.
module load_store_align
  import rv32i_pkg::*;
(
  input  logic        isStore,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] storeData,
  input  logic [31:0] readWord,
  output logic        legal,
  output logic [3:0]  byteEn,
  output logic [31:0] laneData,
  output logic [31:0] loadData
);

  logic [31:0] shifted_s;

  // Unsigned variants exist only for loads; sizes must sit on their natural boundary.
  always_comb begin
    legal = 1'b0;
    case (funct3)
      F3_B:    legal = 1'b1;
      F3_H:    legal = ~off[0];
      F3_W:    legal = (off == 2'b00);
      F3_BU:   legal = ~isStore;
      F3_HU:   legal = ~isStore & ~off[0];
      default: legal = 1'b0;
    endcase
  end

  // Byte enables and replicated store data.
  always_comb begin
    byteEn   = legal ? laneMask(funct3, off) : 4'b0000;
    laneData = storeData;
    case (funct3[1:0])
      2'b00:   laneData = {4{storeData[7:0]}};
      2'b01:   laneData = {2{storeData[15:0]}};
      default: laneData = storeData;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted_s = readWord >> {off, 3'b000};
    loadData  = 32'h0000_0000;
    case (funct3)
      F3_B:    loadData = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_H:    loadData = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_BU:   loadData = {24'h00_0000, shifted_s[7:0]};
      F3_HU:   loadData = {16'h0000, shifted_s[15:0]};
      F3_W:    loadData = readWord;
      default: loadData = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/memory_cycle.sv
// RV32I memory stage: issues data-memory accesses, stalls until the memory
// answers, and registers the MEM/WB pipeline outputs.
module memory_cycle
  import rv32i_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RegWriteM,
  input  logic          MemWriteM,
  input  logic [1:0]    ResultSrcM,
  input  logic [2:0]    funct3M,
  input  logic [4:0]    RdM,
  input  logic [31:0]   ALUResultM,
  input  logic [31:0]   WriteDataM,
  input  logic [31:0]   PCPlus4M,
  memory_cycle_if.master dmem,
  output logic          RegWriteW,
  output logic [1:0]    ResultSrcW,
  output logic [4:0]    RdW,
  output logic [31:0]   ALUResultW,
  output logic [31:0]   ReadDataW,
  output logic [31:0]   PCPlus4W,
  output logic          StallM,
  output logic          MisalignM
);

  memState_e   state_r;
  logic        isLoad_s;
  logic        memOp_s;
  logic        legal_s;
  logic        req_s;
  logic [3:0]  be_s;
  logic [31:0] laneData_s;
  logic [31:0] loadData_s;

  assign isLoad_s = ~MemWriteM & (ResultSrcM == RES_MEM);
  assign memOp_s  = MemWriteM | (ResultSrcM == RES_MEM);
  assign req_s    = memOp_s & legal_s;

  load_store_align u_align (
    .isStore   (MemWriteM),
    .funct3    (funct3M),
    .off       (ALUResultM[1:0]),
    .storeData (WriteDataM),
    .readWord  (dmem.dmem_rdata),
    .legal     (legal_s),
    .byteEn    (be_s),
    .laneData  (laneData_s),
    .loadData  (loadData_s)
  );

  // The EX/MEM inputs are frozen by StallM, so the bus holds steady while waiting.
  assign dmem.dmem_req   = req_s;
  assign dmem.dmem_we    = MemWriteM;
  assign dmem.dmem_addr  = {ALUResultM[ADDR_W-1:2], 2'b00};
  assign dmem.dmem_be    = be_s;
  assign dmem.dmem_wdata = laneData_s;
  assign StallM          = req_s & ~dmem.dmem_ready;

  // Handshake tracking: WAIT while an issued access has not been acknowledged.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s && !dmem.dmem_ready) state_r <= WAIT;
          else                           state_r <= IDLE;
        end
        WAIT: begin
          if (dmem.dmem_ready) state_r <= IDLE;
          else                 state_r <= WAIT;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // MEM/WB register: a stall loads a bubble; a rejected access never writes back.
  always_ff @(posedge clk) begin
    if (rst || StallM) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RdW        <= 5'd0;
      ALUResultW <= 32'h0000_0000;
      ReadDataW  <= 32'h0000_0000;
      PCPlus4W   <= 32'h0000_0000;
      MisalignM  <= 1'b0;
    end else begin
      RegWriteW  <= RegWriteM & ~(memOp_s & ~legal_s);
      ResultSrcW <= ResultSrcM;
      RdW        <= RdM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= (isLoad_s & legal_s) ? loadData_s : 32'h0000_0000;
      PCPlus4W   <= PCPlus4M;
      MisalignM  <= memOp_s & ~legal_s;
    end
  end

endmodule
